ws2812_tx: RTL and testbench
============================

Name: ws2812_tx

Overview:
- Serial LED-strip transmitter: the generating end of the single-wire NRZ pulse-width protocol that the LED reader front end samples.
- Accepts 24-bit pixels over a valid/ready stream and emits one bit per BIT_CYC clocks, MSB first.
- Closes each frame with a low latch period.
- Sits between the pixel source (framebuffer or test pattern) and the strip data pin; also drives the loopback bench for the reader.

Parameters:
- T0H_CYC, 24, clocks high for a '0' bit
- T1H_CYC, 48, clocks high for a '1' bit
- BIT_CYC, 75, total clocks per bit; requires 0 < T0H_CYC < T1H_CYC < BIT_CYC
- LATCH_CYC, 6000, clocks low after the last pixel of a frame (latch/reset)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- pixel_data  input  24  pixel; bit 23 is sent first; channel order is the caller's concern
- pixel_valid  input  1  pixel_data/pixel_last are valid
- pixel_last  input  1  marks the final pixel of a frame
- pixel_ready  output  1  transmitter accepts a pixel this cycle
- data_out  output  1  strip data line
- busy  output  1  high whenever not in IDLE
- underrun  output  1  sticky mid-frame starvation flag (see Optional Feature)

Behaviour:
- Reset (reset low, async): state=IDLE, data_out=0, pixel_ready=0 during reset, busy=0, underrun=0, all counters 0. Reset mid-bit aborts immediately; data_out drops low asynchronously.
- Handshake: transfer occurs when pixel_valid && pixel_ready. pixel_ready is combinational from state/counters only, never from pixel_valid.
- pixel_ready=1 in IDLE, and in the final clock of bit 0 of a pixel unless that pixel had pixel_last.
- States:
  - IDLE: data_out=0. On transfer: load shift reg and last flag, bit_idx=23, cnt=0 -> BIT.
  - BIT: cnt counts 0..BIT_CYC-1. data_out=1 while cnt < (shift[23] ? T1H_CYC : T0H_CYC), else 0.
  - At cnt=BIT_CYC-1 with bit_idx>0: shift left, bit_idx--, cnt=0.
  - At cnt=BIT_CYC-1 with bit_idx=0:
    - last flag set -> LATCH, cnt=0.
    - transfer this cycle -> load new pixel, stay in BIT (zero-gap back-to-back).
    - otherwise -> IDLE (underrun).
  - LATCH: data_out=0 for LATCH_CYC clocks, pixel_ready=0. At cnt=LATCH_CYC-1 -> IDLE.
- Latency: transfer in cycle N gives data_out rising in cycle N+1. A pixel occupies exactly 24*BIT_CYC clocks; a frame of P pixels occupies 24*P*BIT_CYC + LATCH_CYC clocks of busy when fed without gaps.
- data_out is registered (glitch-free pin).
- Counter width: $clog2(max(BIT_CYC, LATCH_CYC)). No wrap; counters are cleared at every state change.
- pixel_last on a pixel accepted from IDLE is honoured the same as back-to-back (single-pixel frame is legal).
- pixel_valid deasserted with pixel_ready high has no effect; held pixel_data may change freely until transfer.

Optional Feature:
- Macro: WS2812_TX_UNDERRUN_EN.
- Defined:
  - underrun sets when BIT ends at bit_idx=0 with no last flag and no transfer (mid-frame starvation).
  - Stays set until reset. A later pixel resumes normally.
  - Note: a starvation gap longer than the strip latch time corrupts the frame on real hardware, hence the flag.
- Undefined: underrun is tied to 0 and no flag logic is synthesised; starvation behaviour (drop to IDLE) is identical.

Decomposition:
- Package ws2812_tx_pkg:
  - PIXEL_W=24.
  - State enum {IDLE, BIT, LATCH}.
  - Default timing constants for 12 MHz clk (T0H=4, T1H=8, BIT=15, LATCH=1200) as named localparams for top-level use.
- One natural sub-module: ws2812_bit_timer (the cnt counter with terminal-count and high-phase compare outputs). The FSM and shift register stay in ws2812_tx.

Test Plan (T0H_CYC=2, T1H_CYC=4, BIT_CYC=6, LATCH_CYC=10):
1. Reset held low, then released with pixel_valid=0 -> data_out=0, pixel_ready=1, busy=0 indefinitely.
2. Single pixel 24'h800001, last=1 -> bit23 high 4 clk/low 2, bits 22..1 high 2/low 4, bit0 high 4/low 2; then 10 clk low with pixel_ready=0; busy for 154 clk total.
3. Two pixels 24'hFFFFFF then 24'h000000 (last), valid held -> second accepted in final clock of first pixel; no gap; 48 bits contiguous (288 clk) then latch.
4. Pixel 24'hAAAAAA (last=0), valid then dropped -> after 144 clk state IDLE, data_out=0; with macro underrun=1, without macro underrun=0; a next pixel with last=1 transmits correctly.
5. Reset asserted mid-bit while data_out=1 -> data_out=0 immediately (async); after release, IDLE with pixel_ready=1 and underrun=0.
6. Valid asserted during LATCH -> pixel_ready=0 until latch completes; accepted on the first IDLE cycle; data_out rises the next clock.

Source files
------------

// File: rtl/ws2812_tx_pkg.sv
// Shared types and default 12 MHz timing for the WS2812 serial LED transmitter.
package ws2812_tx_pkg;

    localparam int unsigned PIXEL_W = 24;

    // Default pulse timing for a 12 MHz system clock
    localparam int unsigned T0H_CYC_12MHZ   = 4;
    localparam int unsigned T1H_CYC_12MHZ   = 8;
    localparam int unsigned BIT_CYC_12MHZ   = 15;
    localparam int unsigned LATCH_CYC_12MHZ = 1200;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIT   = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Shared bit/latch cycle counter with terminal-count flags and a look-ahead
// high-phase compare so the data pin can be registered without extra latency.
module ws2812_bit_timer #(
    parameter int unsigned T0H_CYC   = 24,
    parameter int unsigned T1H_CYC   = 48,
    parameter int unsigned BIT_CYC   = 75,
    parameter int unsigned LATCH_CYC = 6000,
    parameter int unsigned CNT_W     = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic one_next,
    output logic bit_tc_c,
    output logic latch_tc_c,
    output logic high_next_c
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    assign cnt_n = clr ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

    assign bit_tc_c    = (cnt == CNT_W'(BIT_CYC - 1));
    assign latch_tc_c  = (cnt == CNT_W'(LATCH_CYC - 1));
    // Compare on the next count value: data_out is loaded one clock ahead
    assign high_next_c = (cnt_n < (one_next ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC)));

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 NRZ pulse-width transmitter: 24-bit pixels in, MSB-first bit stream out,
// frame closed by a low latch period. Define WS2812_TX_UNDERRUN_EN for the sticky
// mid-frame starvation flag on underrun.
module ws2812_tx
    import ws2812_tx_pkg::*;
#(
    parameter int unsigned T0H_CYC   = 24,
    parameter int unsigned T1H_CYC   = 48,
    parameter int unsigned BIT_CYC   = 75,
    parameter int unsigned LATCH_CYC = 6000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_valid,
    input  logic               pixel_last,
    output logic               pixel_ready,
    output logic               data_out,
    output logic               busy,
    output logic               underrun
);

    localparam int unsigned CNT_MAX = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned IDX_W   = $clog2(PIXEL_W);

    state_t           state,   state_n;
    pixel_t           shift,   shift_n;
    logic [IDX_W-1:0] bit_idx, bit_idx_n;
    logic             last_q,  last_n;
    logic             clr;
    logic             xfer;
    logic             bit_tc;
    logic             latch_tc;
    logic             high_next;
    logic             final_clk;

    ws2812_bit_timer #(
        .T0H_CYC   (T0H_CYC),
        .T1H_CYC   (T1H_CYC),
        .BIT_CYC   (BIT_CYC),
        .LATCH_CYC (LATCH_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .one_next    (shift_n[PIXEL_W-1]),
        .bit_tc_c    (bit_tc),
        .latch_tc_c  (latch_tc),
        .high_next_c (high_next)
    );

    assign final_clk   = (state == BIT) && bit_tc && (bit_idx == '0);
    // Ready depends on state/counters only; held low while reset is asserted
    assign pixel_ready = reset && ((state == IDLE) || (final_clk && !last_q));
    assign xfer        = pixel_valid && pixel_ready;

    // Next-state, shift register and counter-clear decode
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        last_n    = last_q;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (xfer) begin
                    shift_n   = pixel_data;
                    bit_idx_n = IDX_W'(PIXEL_W - 1);
                    last_n    = pixel_last;
                    state_n   = BIT;
                end
            end
            BIT: begin
                if (bit_tc) begin
                    clr = 1'b1;
                    if (bit_idx != '0) begin
                        shift_n   = {shift[PIXEL_W-2:0], 1'b0};
                        bit_idx_n = bit_idx - IDX_W'(1);
                    end else if (last_q) begin
                        state_n = LATCH;
                    end else if (xfer) begin
                        shift_n   = pixel_data;
                        bit_idx_n = IDX_W'(PIXEL_W - 1);
                        last_n    = pixel_last;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            LATCH: begin
                if (latch_tc) begin
                    clr     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                clr     = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            last_q   <= 1'b0;
            data_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            last_q   <= last_n;
            data_out <= (state_n == BIT) && high_next;
            busy     <= (state_n != IDLE);
        end
    end

`ifdef WS2812_TX_UNDERRUN_EN
    logic starve;

    // Pixel ended mid-frame with nothing queued behind it
    assign starve = final_clk && !last_q && !xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed scoreboard bench for ws2812_tx with short timing (2/4/6/10 clocks).
module tb_ws2812_tx;

    localparam int unsigned T0H   = 2;
    localparam int unsigned T1H   = 4;
    localparam int unsigned BITC  = 6;
    localparam int unsigned LATCH = 10;
    localparam int          LIMIT = 3000;
`ifdef WS2812_TX_UNDERRUN_EN
    localparam logic EXP_UR = 1'b1;
`else
    localparam logic EXP_UR = 1'b0;
`endif

    typedef struct packed {
        logic d;
        logic b;
        logic r;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_last;
    logic        pixel_ready;
    logic        data_out;
    logic        busy;
    logic        underrun;

    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;
    logic mon_en = 1'b0;
    exp_t exp_q[$];

    ws2812_tx #(
        .T0H_CYC   (T0H),
        .T1H_CYC   (T1H),
        .BIT_CYC   (BITC),
        .LATCH_CYC (LATCH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_last  (pixel_last),
        .pixel_ready (pixel_ready),
        .data_out    (data_out),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected per-clock pin/busy/ready for one accepted pixel (plus latch if last)
    task automatic push_pixel(input logic [23:0] px, input logic l);
        exp_t e;
        int   bitn;
        int   c;
        for (int i = 0; i < 24 * BITC; i++) begin
            bitn = 23 - i / BITC;
            c    = i % BITC;
            e.d  = (c < (px[bitn] ? T1H : T0H));
            e.b  = 1'b1;
            e.r  = (i == 24 * BITC - 1) && !l;
            exp_q.push_back(e);
        end
        if (l) begin
            for (int i = 0; i < LATCH; i++) begin
                exp_q.push_back('{d: 1'b0, b: 1'b1, r: 1'b0});
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer
    task automatic send(input logic [23:0] d, input logic l, output int waited);
        waited      = 0;
        pixel_data  = d;
        pixel_last  = l;
        pixel_valid = 1'b1;
        while (!pixel_ready && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= LIMIT) begin
            chk("send_timeout", 32'(waited), 32'(LIMIT - 1));
        end else begin
            push_pixel(d, l);
            @(negedge clk);
        end
        pixel_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(n < LIMIT), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Per-clock scoreboard check just after each rising edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en && reset) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '{d: 1'b0, b: 1'b0, r: 1'b1};
            chk("data_out", 32'(data_out), 32'(e.d));
            chk("busy", 32'(busy), 32'(e.b));
            chk("pixel_ready", 32'(pixel_ready), 32'(e.r));
            if (busy) busy_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset       = 1'b0;
        pixel_data  = '0;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;

        // 1: reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_ready", 32'(pixel_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_ready", 32'(pixel_ready), 32'd1);
        mon_en = 1'b1;
        repeat (20) @(negedge clk);

        // 2: single-pixel frame
        busy_cnt = 0;
        send(24'h800001, 1'b1, w);
        chk("single_wait", 32'(w), 32'd0);
        drain();
        chk("single_busy_len", 32'(busy_cnt), 32'd154);

        // 3: back-to-back two-pixel frame
        busy_cnt = 0;
        send(24'hFFFFFF, 1'b0, w);
        send(24'h000000, 1'b1, w);
        chk("b2b_accept_clk", 32'(w), 32'd143);
        drain();
        chk("b2b_busy_len", 32'(busy_cnt), 32'd298);

        // 4: starvation mid-frame, then resume
        busy_cnt = 0;
        send(24'hAAAAAA, 1'b0, w);
        drain();
        chk("starve_busy_len", 32'(busy_cnt), 32'd144);
        chk("starve_busy", 32'(busy), 32'd0);
        chk("starve_data_out", 32'(data_out), 32'd0);
        chk("starve_underrun", 32'(underrun), 32'(EXP_UR));
        send(24'h123456, 1'b1, w);
        drain();
        chk("resume_underrun", 32'(underrun), 32'(EXP_UR));

        // 5: asynchronous reset during a high phase
        send(24'hFFFFFF, 1'b1, w);
        chk("pre_rst_data_out", 32'(data_out), 32'd1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        exp_q.delete();
        chk("async_data_out", 32'(data_out), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_ready", 32'(pixel_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 32'(pixel_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_underrun", 32'(underrun), 32'd0);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // 6: valid held through the latch period
        send(24'h000001, 1'b1, w);
        send(24'h800000, 1'b1, w);
        chk("latch_hold_wait", 32'(w), 32'd154);
        @(posedge clk);
        #1;
        chk("latch_next_rise", 32'(data_out), 32'd1);
        @(negedge clk);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
